// File: rtl/tick_timeout_watchdog.sv
// Tick-based watchdog: once armed it counts timebase ticks up to a latched limit.
// It reports a timeout at the limit, or reports completion with the elapsed count when the awaited event arrives first.
module tick_timeout_watchdog #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] limit,
  input  logic                   done,
  input  logic                   abort,
  output logic                   busy,
  output logic                   timeout,
  output logic                   finished,
  output logic [COUNT_WIDTH-1:0] elapsed
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] limit_q, limit_d;
  logic [COUNT_WIDTH-1:0] elapsed_q, elapsed_d;
  logic                   timeout_q, timeout_d;
  logic                   finished_q, finished_d;

  logic [COUNT_WIDTH-1:0] countNext;
  logic                   limitHit;

  // The count includes this cycle's tick, so the limit and done both see it, and the count saturates at the limit.
  always_comb begin
    countNext = count_q;
    if (tick && (count_q != limit_q)) begin
      countNext = count_q + ONE;
    end
    limitHit = (countNext == limit_q);
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    elapsed_d  = elapsed_q;
    timeout_d  = 1'b0;
    finished_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          limit_d = limit;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (done) begin
          finished_d = 1'b1;
          elapsed_d  = countNext;
          count_d    = '0;
          state_d    = IDLE;
        end else if (start) begin
          limit_d = limit;
          count_d = '0;
        end else if (limitHit) begin
          timeout_d = 1'b1;
          elapsed_d = limit_q;
          count_d   = '0;
          state_d   = IDLE;
        end else begin
          count_d = countNext;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      limit_q    <= '0;
      elapsed_q  <= '0;
      timeout_q  <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      elapsed_q  <= elapsed_d;
      timeout_q  <= timeout_d;
      finished_q <= finished_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign timeout  = timeout_q;
  assign finished = finished_q;
  assign elapsed  = elapsed_q;

endmodule
